// File: rtl/entropy_key_harvester_if.sv
// Byte-stream handshake carrying harvested key material to the consumer.
interface entropy_key_harvester_if;
    logic [7:0] key_byte;
    logic       key_valid;
    logic       key_accept;
    logic       key_last;

    modport master (output key_byte, key_valid, key_last, input key_accept);
    modport slave  (input key_byte, key_valid, key_last, output key_accept);
endinterface

// File: rtl/entropy_key_harvester.sv
// Waits for MIN_PASSES full overwrites of the entropy pool, snapshots it and streams it out byte-wise.
// Optional pool health check (all-zeros / all-ones reject) enabled by KEY_HEALTH_CHECK_EN.
module entropy_key_harvester #(
    parameter int unsigned POOL_BITS  = 256,
    parameter int unsigned MIN_PASSES = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 sample_ready,
    input  logic [POOL_BITS-1:0] pool,
    input  logic                 key_request,
    entropy_key_harvester_if.master key_if,
    output logic                 busy,
    output logic                 harvest_done,
    output logic                 health_fail
);

    localparam int unsigned TARGET = POOL_BITS * MIN_PASSES;
    localparam int unsigned CNT_W  = $clog2(TARGET) + 1;
    localparam int unsigned NBYTES = POOL_BITS / 8;
    localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(TARGET);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NBYTES - 1);

    typedef enum logic [2:0] {
        IDLE, COLLECT, SETTLE, LATCH, STREAM, DONE
    } state_t;

    state_t               state, state_n;
    logic                 old_ready;
    logic                 edge_c;
    logic [CNT_W-1:0]     count, count_n;
    logic [POOL_BITS-1:0] snapshot, snap_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic                 hfail_n;
    logic [7:0]           key_byte_q;
    logic                 key_valid_q;
    logic                 key_last_q;

    assign edge_c           = sample_ready & ~old_ready;
    assign key_if.key_byte  = key_byte_q;
    assign key_if.key_valid = key_valid_q;
    assign key_if.key_last  = key_last_q;

    // Next-state, counter, snapshot and byte-index logic
    always_comb begin
        state_n = state;
        count_n = count;
        snap_n  = snapshot;
        idx_n   = idx;
        hfail_n = 1'b0;
        case (state)
            IDLE: begin
                if (key_request) begin
                    state_n = COLLECT;
                    count_n = '0;
                end
            end
            COLLECT: begin
                if (edge_c && (count != '1)) begin
                    count_n = count + CNT_W'(1);
                end
                // Leave in the same cycle the final edge is registered
                if (count_n == CNT_TARGET) begin
                    state_n = SETTLE;
                end
            end
            SETTLE: state_n = LATCH;
            LATCH: begin
`ifdef KEY_HEALTH_CHECK_EN
                if ((pool == '0) || (pool == '1)) begin
                    hfail_n = 1'b1;
                    snap_n  = '0;
                    count_n = '0;
                    state_n = COLLECT;
                end else begin
                    snap_n  = pool;
                    idx_n   = '0;
                    state_n = STREAM;
                end
`else
                snap_n  = pool;
                idx_n   = '0;
                state_n = STREAM;
`endif
            end
            STREAM: begin
                if (key_valid_q && key_if.key_accept) begin
                    if (idx == IDX_LAST) begin
                        state_n = DONE;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                snap_n  = '0;
                idx_n   = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs, derived from next-state so latency is minimal
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            old_ready    <= 1'b0;
            count        <= '0;
            snapshot     <= '0;
            idx          <= '0;
            key_byte_q   <= '0;
            key_valid_q  <= 1'b0;
            key_last_q   <= 1'b0;
            busy         <= 1'b0;
            harvest_done <= 1'b0;
        end else begin
            state        <= state_n;
            old_ready    <= sample_ready;
            count        <= count_n;
            snapshot     <= snap_n;
            idx          <= idx_n;
            key_valid_q  <= (state_n == STREAM);
            key_last_q   <= (state_n == STREAM) && (idx_n == IDX_LAST);
            key_byte_q   <= (state_n == STREAM) ? snap_n[{idx_n, 3'b000} +: 8] : 8'h00;
            busy         <= (state_n != IDLE);
            harvest_done <= (state_n == DONE);
        end
    end

`ifdef KEY_HEALTH_CHECK_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            health_fail <= 1'b0;
        end else begin
            health_fail <= hfail_n;
        end
    end
`else
    assign health_fail = 1'b0;
    logic unused_hfail;
    assign unused_hfail = hfail_n;
`endif

endmodule

// File: tb/tb_entropy_key_harvester.sv
// Directed bench for entropy_key_harvester: latency, streaming, back-pressure, reset abort, health check.
module tb_entropy_key_harvester;
    localparam int unsigned POOL_BITS = 256;
    localparam int unsigned NB        = POOL_BITS / 8;
    localparam int unsigned STROBES   = POOL_BITS * 4;

    typedef struct {
        logic       accept;
        logic       valid;
        logic [7:0] byte_v;
        logic       last;
        logic       done;
        logic       busy;
    } vec_t;

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic                 sample_ready;
    logic [POOL_BITS-1:0] pool;
    logic                 key_request;
    logic                 busy;
    logic                 harvest_done;
    logic                 health_fail;

    int checks = 0;
    int errors = 0;
    int hf_seen = 0;

    entropy_key_harvester_if kif ();

    always #5 clock = ~clock;

    entropy_key_harvester #(.POOL_BITS(POOL_BITS), .MIN_PASSES(4)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .sample_ready (sample_ready),
        .pool         (pool),
        .key_request  (key_request),
        .key_if       (kif.master),
        .busy         (busy),
        .harvest_done (harvest_done),
        .health_fail  (health_fail)
    );

    always @(negedge clock) if (health_fail) hf_seen++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [POOL_BITS-1:0] ramp_pool();
        logic [POOL_BITS-1:0] p;
        for (int i = 0; i < NB; i++) p[8*i +: 8] = 8'(i);
        return p;
    endfunction

    function automatic logic [7:0] pat_byte(input int i);
        return 8'((i * 37 + 5) & 255);
    endfunction

    function automatic logic [POOL_BITS-1:0] pat_pool();
        logic [POOL_BITS-1:0] p;
        for (int i = 0; i < NB; i++) p[8*i +: 8] = pat_byte(i);
        return p;
    endfunction

    task automatic request();
        key_request = 1'b1;
        tick();
        key_request = 1'b0;
    endtask

    task automatic strobes(input int n, input int req_at);
        for (int i = 0; i < n; i++) begin
            sample_ready = 1'b1;
            key_request  = (i == req_at);
            tick();
            key_request  = 1'b0;
            sample_ready = 1'b0;
            tick();
        end
    endtask

    // Final strobe: valid must rise exactly two cycles after the edge is registered
    task automatic final_strobe(input string tag, input logic [7:0] first);
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
        chk({tag, "_lat0"}, 32'(kif.key_valid), 32'd0);
        tick();
        chk({tag, "_lat1"}, 32'(kif.key_valid), 32'd0);
        tick();
        chk({tag, "_lat2"}, 32'(kif.key_valid), 32'd1);
        chk({tag, "_first"}, 32'(kif.key_byte), 32'(first));
    endtask

    task automatic drain(input string tag);
        int seen = 0;
        kif.key_accept = 1'b1;
        for (int c = 0; c < 64 && seen == 0; c++) begin
            tick();
            if (harvest_done) seen = 1;
        end
        kif.key_accept = 1'b0;
        chk({tag, "_drain_done"}, 32'(seen), 32'd1);
        tick();
    endtask

    initial begin
        vec_t tbl[NB+2];
        int   idx, xfers, done;
        logic acc, v;
        logic [31:0] apat;

        for (int i = 0; i < NB; i++)
            tbl[i] = '{accept: 1'b1, valid: 1'b1, byte_v: 8'(i), last: 1'(i == NB-1), done: 1'b0, busy: 1'b1};
        tbl[NB]   = '{accept: 1'b0, valid: 1'b0, byte_v: 8'h00, last: 1'b0, done: 1'b1, busy: 1'b1};
        tbl[NB+1] = '{accept: 1'b0, valid: 1'b0, byte_v: 8'h00, last: 1'b0, done: 1'b0, busy: 1'b0};

        reset_n = 1'b0; sample_ready = 1'b0; key_request = 1'b0;
        kif.key_accept = 1'b0; pool = ramp_pool();
        #12;
        chk("rst_valid", 32'(kif.key_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(harvest_done), 32'd0);
        chk("rst_last", 32'(kif.key_last), 32'd0);
        chk("rst_byte", 32'(kif.key_byte), 32'd0);
        chk("rst_hfail", 32'(health_fail), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Harvest 1: key_request mid-COLLECT must not restart the count
        request();
        chk("h1_busy", 32'(busy), 32'd1);
        strobes(STROBES - 1, 500);
        tick(); tick();
        chk("h1_1023_valid", 32'(kif.key_valid), 32'd0);
        chk("h1_1023_busy", 32'(busy), 32'd1);
        final_strobe("h1", 8'h00);
        for (int i = 0; i < NB + 2; i++) begin
            kif.key_accept = tbl[i].accept;
            chk($sformatf("tbl%0d_valid", i), 32'(kif.key_valid), 32'(tbl[i].valid));
            chk($sformatf("tbl%0d_byte", i), 32'(kif.key_byte), 32'(tbl[i].byte_v));
            chk($sformatf("tbl%0d_last", i), 32'(kif.key_last), 32'(tbl[i].last));
            chk($sformatf("tbl%0d_done", i), 32'(harvest_done), 32'(tbl[i].done));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            tick();
        end
        kif.key_accept = 1'b0;

        // Harvest 2: back-pressure, pool changes after LATCH, request mid-STREAM
        pool = pat_pool();
        request();
        strobes(STROBES - 1, -1);
        final_strobe("h2", pat_byte(0));
        apat = 32'b1011_0010_0110_1101_0001_1110_1001_0111;
        idx = 0; xfers = 0; done = 0;
        for (int c = 0; c < 200 && done == 0; c++) begin
            acc = apat[c % 32];
            kif.key_accept = acc;
            v = kif.key_valid;
            if (v) begin
                chk($sformatf("h2_byte%0d", idx), 32'(kif.key_byte), 32'(pat_byte(idx)));
                chk($sformatf("h2_last%0d", idx), 32'(kif.key_last), 32'(idx == NB - 1));
            end
            key_request = (c == 10);
            if (c == 5) pool = {8{$urandom()}};
            tick();
            key_request = 1'b0;
            if (v && acc) begin
                xfers++;
                idx++;
            end
            if (harvest_done) done = 1;
        end
        kif.key_accept = 1'b0;
        chk("h2_xfers", 32'(xfers), 32'(NB));
        chk("h2_done", 32'(done), 32'd1);
        tick();
        chk("h2_idle", 32'(busy), 32'd0);

        // Harvest 3: reset at byte 10 abandons the stream
        pool = ramp_pool();
        request();
        strobes(STROBES - 1, -1);
        final_strobe("h3", 8'h00);
        kif.key_accept = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        kif.key_accept = 1'b0;
        chk("h3_byte10", 32'(kif.key_byte), 32'h0a);
        #2;
        reset_n = 1'b0;
        #1;
        chk("h3_rst_valid", 32'(kif.key_valid), 32'd0);
        chk("h3_rst_busy", 32'(busy), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        request();
        strobes(STROBES - 1, -1);
        tick(); tick();
        chk("h3b_1023_valid", 32'(kif.key_valid), 32'd0);
        final_strobe("h3b", 8'h00);
        drain("h3b");

`ifdef KEY_HEALTH_CHECK_EN
        // All-ones pool is rejected; the next full collection streams normally
        begin
            int hf = 0, vs = 0;
            pool = '1;
            request();
            strobes(STROBES - 1, -1);
            sample_ready = 1'b1;
            tick();
            sample_ready = 1'b0;
            for (int c = 0; c < 6; c++) begin
                tick();
                if (health_fail) hf++;
                if (kif.key_valid) vs++;
            end
            chk("hc_pulse", 32'(hf), 32'd1);
            chk("hc_novalid", 32'(vs), 32'd0);
            chk("hc_busy", 32'(busy), 32'd1);
            pool = pat_pool();
            strobes(STROBES - 1, -1);
            final_strobe("hc2", pat_byte(0));
            drain("hc2");
        end
`else
        chk("hfail_never", 32'(hf_seen), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
